// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : card_pkg
//  Description : Shared constants and types for the card sprite read path.
//                A card image is CARD_W x CARD_H pixels of COLOR_W-bit colour,
//                stored row-major as {row, col} in a 512-entry memory.
//  Revision    : 1.0  initial release
// ============================================================================
package card_pkg;

    localparam int CARD_W   = 16;   // card width, power of two
    localparam int CARD_H   = 32;   // card height
    localparam int CARD_AW  = 9;    // card memory address width
    localparam int COLOR_W  = 3;    // colour code width
    localparam int H_ACTIVE = 256;  // visible columns
    localparam int V_ACTIVE = 240;  // visible rows

    localparam logic [COLOR_W-1:0] TRANSPARENT = 3'b000;

    // Address split: low bits select the column, high bits the row.
    localparam int COL_W = $clog2(CARD_W);
    localparam int ROW_W = CARD_AW - COL_W;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [CARD_AW-1:0] card_addr_t;

endpackage : card_pkg
`default_nettype wire

// File: rtl/card_hit_calc.sv
`default_nettype none
// ============================================================================
//  Module      : card_hit_calc
//  Description : Combinational hit test of the beam against one card and the
//                {row, col} address of the pixel under the beam.
//  Ports       : hcount/vcount/pix_valid - beam position and qualifier
//                card_en/x_pos/y_pos     - latched card visibility/position
//                hit                     - beam is on a visible card pixel
//                addr                    - card memory address of that pixel
//  Revision    : 1.0  initial release
// ============================================================================
module card_hit_calc
    import card_pkg::*;
(
    input  logic [8:0]         hcount,
    input  logic [8:0]         vcount,
    input  logic               pix_valid,
    input  logic               card_en,
    input  logic [8:0]         x_pos,
    input  logic [7:0]         y_pos,
    output logic               hit,
    output logic [CARD_AW-1:0] addr
);

    // Ten-bit compares so a card hanging off the right or bottom edge is
    // clipped rather than wrapping back to column/row 0.
    logic [9:0] w_h;
    logic [9:0] w_v;
    logic [9:0] w_x;
    logic [9:0] w_y;
    logic [9:0] w_x_end;
    logic [9:0] w_y_end;
    logic       w_in_screen;
    logic       w_in_card;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;

    assign w_h     = {1'b0, hcount};
    assign w_v     = {1'b0, vcount};
    assign w_x     = {1'b0, x_pos};
    assign w_y     = {2'b00, y_pos};
    assign w_x_end = w_x + 10'(CARD_W);
    assign w_y_end = w_y + 10'(CARD_H);

    assign w_in_screen = (w_h < 10'(H_ACTIVE)) && (w_v < 10'(V_ACTIVE));
    assign w_in_card   = (w_h >= w_x) && (w_h < w_x_end) &&
                         (w_v >= w_y) && (w_v < w_y_end);

    assign hit = pix_valid && card_en && w_in_screen && w_in_card;

    // Only the low bits of the offsets matter; they are meaningful on a hit.
    assign w_col = COL_W'(hcount - x_pos);
    assign w_row = ROW_W'(vcount - {1'b0, y_pos});
    assign addr  = {w_row, w_col};

endmodule : card_hit_calc
`default_nettype wire

// File: rtl/card_sprite_reader.sv
`default_nettype none
// ============================================================================
//  Module      : card_sprite_reader
//  Description : Read-side client of one 512x3 card image memory. Compares
//                the VGA beam with the card position latched at frame start,
//                issues one read per hit pixel and aligns the returned colour
//                with the memory's registered read. Fixed 3-clock latency from
//                hcount/vcount to pixel_out/pixel_on, no stalls.
//  Ports       : clock, reset_n (async, active low)
//                frame_start, card_en, x_pos, y_pos - per-frame card setup
//                hcount, vcount, pix_valid          - beam position
//                rAddr, RE, dataIn                  - card memory read port
//                pixel_out, pixel_on                - colour to pixel mux
//                busy                               - read in flight
//  Revision    : 1.0  initial release
// ============================================================================
module card_sprite_reader
    import card_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               card_en,
    input  logic [8:0]         x_pos,
    input  logic [7:0]         y_pos,
    input  logic [8:0]         hcount,
    input  logic [8:0]         vcount,
    input  logic               pix_valid,
    output logic [CARD_AW-1:0] rAddr,
    output logic               RE,
    input  logic [COLOR_W-1:0] dataIn,
    output logic [COLOR_W-1:0] pixel_out,
    output logic               pixel_on,
    output logic               busy
);

    // Shadow copies of the card setup, stable for the whole frame.
    logic       r_card_en_q;
    logic [8:0] r_x_q;
    logic [7:0] r_y_q;

    // Pipeline state.
    card_addr_t r_addr;
    logic       r_re;
    logic       r_v1;
    logic       r_v2;
    color_t     r_pixel;
    logic       r_on;

    logic       w_hit;
    card_addr_t w_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_card_en_q <= 1'b0;
            r_x_q       <= '0;
            r_y_q       <= '0;
        end else if (frame_start) begin
            r_card_en_q <= card_en;
            r_x_q       <= x_pos;
            r_y_q       <= y_pos;
        end
    end

    card_hit_calc u_hit_calc (
        .hcount    (hcount),
        .vcount    (vcount),
        .pix_valid (pix_valid),
        .card_en   (r_card_en_q),
        .x_pos     (r_x_q),
        .y_pos     (r_y_q),
        .hit       (w_hit),
        .addr      (w_addr)
    );

    // Stage 1 issues the read; the address holds on a miss so the memory
    // port is quiet between hits. Stage 2 is the memory's own register, so
    // only the valid bit travels here. Stage 3 registers the colour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_re    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_pixel <= '0;
            r_on    <= 1'b0;
        end else begin
            if (w_hit) begin
                r_addr <= w_addr;
            end
            r_re    <= w_hit;
            r_v1    <= w_hit;
            r_v2    <= r_v1;
            r_pixel <= r_v2 ? dataIn : '0;
            r_on    <= r_v2 && (dataIn != TRANSPARENT);
        end
    end

    assign rAddr     = r_addr;
    assign RE        = r_re;
    assign pixel_out = r_pixel;
    assign pixel_on  = r_on;
    assign busy      = r_v1 | r_v2;

endmodule : card_sprite_reader
`default_nettype wire

// File: tb/tb_card_sprite_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_card_sprite_reader
//  Description : Self-checking bench for card_sprite_reader with a behavioural
//                registered-read card memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_card_sprite_reader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       card_en;
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       pix_valid;
    logic [8:0] rAddr;
    logic       RE;
    logic [2:0] mem_dout;
    logic [2:0] pixel_out;
    logic       pixel_on;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    card_sprite_reader u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .card_en     (card_en),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .hcount      (hcount),
        .vcount      (vcount),
        .pix_valid   (pix_valid),
        .rAddr       (rAddr),
        .RE          (RE),
        .dataIn      (mem_dout),
        .pixel_out   (pixel_out),
        .pixel_on    (pixel_on),
        .busy        (busy)
    );

    // Card memory: one-cycle registered read.
    logic [2:0] ram [0:511];
    always @(posedge clock) begin
        if (RE) mem_dout <= ram[rAddr];
    end

    typedef struct {
        int h;
        int v;
        bit pv;
        bit re;
        int addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_beam(input int h, input int v, input bit pv);
        hcount    = 9'(h);
        vcount    = 9'(v);
        pix_valid = pv;
    endtask

    task automatic load_card(input int x, input int y, input bit en);
        x_pos       = 9'(x);
        y_pos       = 8'(y);
        card_en     = en;
        frame_start = 1'b1;
        pix_valid   = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic add(input int h, input int v, input bit pv, input bit re, input int addr);
        vec_t e;
        e.h = h; e.v = v; e.pv = pv; e.re = re; e.addr = addr;
        vecs.push_back(e);
    endtask

    // Applies the vector list back to back. After each edge RE/rAddr belong to
    // the current vector and pixel_out/pixel_on to the vector two earlier.
    task automatic run_table(input string tag);
        int e_pix[$];
        int e_on[$];
        int xp;
        int xo;
        set_beam(0, 0, 1'b0);
        repeat (3) tick();
        e_pix = '{0, 0};
        e_on  = '{0, 0};
        foreach (vecs[i]) begin
            set_beam(vecs[i].h, vecs[i].v, vecs[i].pv);
            tick();
            check($sformatf("%s[%0d].RE", tag, i), int'(RE), int'(vecs[i].re));
            check($sformatf("%s[%0d].rAddr", tag, i), int'(rAddr), vecs[i].addr);
            e_pix.push_back(vecs[i].re ? int'(ram[vecs[i].addr]) : 0);
            e_on.push_back((vecs[i].re && ram[vecs[i].addr] != 3'b000) ? 1 : 0);
            xp = e_pix.pop_front();
            xo = e_on.pop_front();
            check($sformatf("%s[%0d].pixel_out", tag, i), int'(pixel_out), xp);
            check($sformatf("%s[%0d].pixel_on", tag, i), int'(pixel_on), xo);
        end
        vecs.delete();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 3'(i);
        ram[0] = 3'b110;
        ram[5] = 3'b000;
        ram[6] = 3'b101;
        mem_dout = 3'b000;

        reset_n = 1'b0;
        frame_start = 1'b0;
        card_en = 1'b0;
        x_pos = '0;
        y_pos = '0;
        set_beam(0, 0, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst.RE", int'(RE), 0);
        check("rst.rAddr", int'(rAddr), 0);
        check("rst.pixel_out", int'(pixel_out), 0);
        check("rst.pixel_on", int'(pixel_on), 0);
        check("rst.busy", int'(busy), 0);
        reset_n = 1'b1;
        tick();

        // Card hidden until a frame_start loads it
        set_beam(0, 0, 1'b1);
        tick();
        check("nocard.RE", int'(RE), 0);

        // First pixel of the card, 1 clock to the read, 3 to the colour
        load_card(40, 20, 1'b1);
        set_beam(40, 20, 1'b1);
        tick();
        check("first.RE", int'(RE), 1);
        check("first.rAddr", int'(rAddr), 0);
        check("first.busy", int'(busy), 1);
        set_beam(0, 0, 1'b0);
        tick();
        check("first.busy2", int'(busy), 1);
        tick();
        check("first.pixel_out", int'(pixel_out), 6);
        check("first.pixel_on", int'(pixel_on), 1);
        check("first.busy3", int'(busy), 0);

        // Row 21 sweep, columns 39..56
        add(39, 21, 1'b1, 1'b0, 0);
        for (int c = 40; c <= 55; c++) add(c, 21, 1'b1, 1'b1, 16 + (c - 40));
        add(56, 21, 1'b1, 1'b0, 31);
        add(41, 21, 1'b0, 1'b0, 31);
        run_table("sweep");

        // Transparent word at 5, opaque 3'b101 at 6
        set_beam(45, 20, 1'b1);
        tick();
        set_beam(46, 20, 1'b1);
        tick();
        set_beam(0, 0, 1'b0);
        tick();
        check("transp.pixel_out", int'(pixel_out), 0);
        check("transp.pixel_on", int'(pixel_on), 0);
        tick();
        check("opaque.pixel_out", int'(pixel_out), 5);
        check("opaque.pixel_on", int'(pixel_on), 1);

        // Position change without frame_start has no effect
        x_pos = 9'd100;
        add(40, 22, 1'b1, 1'b1, 32);
        add(100, 22, 1'b1, 1'b0, 32);
        run_table("midframe");

        // After frame_start the card sits at columns 100..115
        load_card(100, 20, 1'b1);
        add(100, 22, 1'b1, 1'b1, 32);
        add(115, 22, 1'b1, 1'b1, 47);
        add(116, 22, 1'b1, 1'b0, 47);
        add(40, 22, 1'b1, 1'b0, 47);
        add(99, 22, 1'b1, 1'b0, 47);
        run_table("moved");

        // frame_start coincident with a hit: old addressing completes
        load_card(40, 20, 1'b1);
        set_beam(41, 20, 1'b1);
        x_pos = 9'd100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_inflight.RE", int'(RE), 1);
        check("fs_inflight.rAddr", int'(rAddr), 1);
        tick();
        check("fs_after.RE", int'(RE), 0);
        check("fs_after.rAddr", int'(rAddr), 1);
        set_beam(0, 0, 1'b0);
        tick();
        check("fs_inflight.pixel_out", int'(pixel_out), 1);
        check("fs_inflight.pixel_on", int'(pixel_on), 1);

        // Card clipped at right and bottom edges, never wrapped
        load_card(250, 230, 1'b1);
        add(250, 230, 1'b1, 1'b1, 0);
        add(253, 235, 1'b1, 1'b1, 83);
        add(256, 230, 1'b1, 1'b0, 83);
        add(260, 235, 1'b1, 1'b0, 83);
        add(0, 230, 1'b1, 1'b0, 83);
        add(9, 231, 1'b1, 1'b0, 83);
        add(250, 240, 1'b1, 1'b0, 83);
        add(250, 245, 1'b1, 1'b0, 83);
        add(250, 229, 1'b1, 1'b0, 83);
        add(249, 235, 1'b1, 1'b0, 83);
        add(255, 239, 1'b1, 1'b1, 149);
        add(0, 239, 1'b1, 1'b0, 149);
        add(5, 6, 1'b1, 1'b0, 149);
        run_table("clip");

        // Asynchronous reset with reads in flight
        load_card(40, 20, 1'b1);
        set_beam(41, 20, 1'b1);
        tick();
        set_beam(42, 20, 1'b1);
        tick();
        set_beam(43, 20, 1'b1);
        tick();
        check("pre_rst.RE", int'(RE), 1);
        check("pre_rst.pixel_on", int'(pixel_on), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.RE", int'(RE), 0);
        check("async_rst.rAddr", int'(rAddr), 0);
        check("async_rst.pixel_out", int'(pixel_out), 0);
        check("async_rst.pixel_on", int'(pixel_on), 0);
        check("async_rst.busy", int'(busy), 0);
        reset_n = 1'b1;
        tick();
        check("post_rst.RE", int'(RE), 0);
        tick();
        check("post_rst.busy", int'(busy), 0);
        load_card(40, 20, 1'b1);
        set_beam(43, 20, 1'b1);
        tick();
        check("resume.RE", int'(RE), 1);
        check("resume.rAddr", int'(rAddr), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_card_sprite_reader
`default_nettype wire
